// File: rtl/mux_select_accumulator.sv
// mux_select_accumulator
// Consumer stage for the 8-bit garbler/evaluator select path. Each accepted
// sample picks one of two W-bit operands out of g_input, using e_input as the
// selector. The picked operand is folded into a running accumulator until
// NUM_CC samples have been taken. The final value is then flagged with a
// single-cycle done pulse.
//
// Fold function (MODE):
//   0 : modular sum, wraps at 2^ACC_W
//   1 : unsigned running maximum
//
// All outputs come straight from registers, so o/done/busy/cnt change only
// on a rising clock edge.

module mux_select_accumulator #(
  parameter int W      = 8,   // operand width; g_input carries two operands
  parameter int ACC_W  = 16,  // accumulator width, at least W
  parameter int NUM_CC = 8,   // accepted samples per run, 1..65535
  parameter int MODE   = 0    // 0 = modular sum, 1 = unsigned running max
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active-low
  input  logic [2*W-1:0]   g_input,   // {IN1, IN0}
  input  logic             e_input,   // 0 selects IN0, 1 selects IN1
  input  logic             start,
  input  logic             in_valid,
  output logic [ACC_W-1:0] o,
  output logic             done,
  output logic             busy,
  output logic [15:0]      cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sample count at which the next accepted sample completes the run.
  localparam logic [15:0] LAST_CNT = 16'(NUM_CC - 1);

  state_t           state_reg;
  logic [ACC_W-1:0] o_reg;
  logic             done_reg;
  logic             busy_reg;
  logic [15:0]      cnt_reg;

  logic [W-1:0]     sel;
  logic [ACC_W-1:0] sel_ext;
  logic [ACC_W-1:0] fold_next;

  // Operand select, one 2:1 mux per bit: e_input chooses the upper or the
  // lower half of g_input.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_sel
      assign sel[gi] = e_input ? g_input[W + gi] : g_input[gi];
    end
  endgenerate

  // Zero-extend the picked operand to the accumulator width before folding.
  assign sel_ext = ACC_W'(sel);

  // Fold function is fixed at elaboration time. Only one of the two datapaths
  // exists in a given build.
  generate
    if (MODE == 1) begin : g_fold_max
      // Ties keep the current value. Either way the result is identical.
      assign fold_next = (sel_ext > o_reg) ? sel_ext : o_reg;
    end else begin : g_fold_sum
      // Plain modular add: the carry out of the top bit is dropped.
      assign fold_next = o_reg + sel_ext;
    end
  endgenerate

  // Run controller: IDLE/DONE wait for start, RUN folds valid samples until
  // NUM_CC have been accepted. The outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      o_reg     <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // DONE lasts exactly one cycle. During that cycle it accepts start
        // the same way IDLE does, so runs can be chained back-to-back.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            o_reg     <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        // start is ignored here. Cycles without in_valid simply stall the
        // run, and there is no timeout.
        ST_RUN: begin
          if (in_valid) begin
            o_reg   <= fold_next;
            cnt_reg <= cnt_reg + 16'd1;
            if (cnt_reg == LAST_CNT) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= ST_DONE;
            end
          end
        end

        // Unreachable encoding: drop back to a quiet IDLE.
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign o    = o_reg;
  assign done = done_reg;
  assign busy = busy_reg;
  assign cnt  = cnt_reg;

endmodule
